// File: rtl/simple_pipe_pkg.sv
// Shared opcode encoding and ALU behaviour for the simple forwarding pipeline.
package simple_pipe_pkg;

    localparam int OP_W = 3;

    localparam logic [OP_W-1:0] OP_NOP = 3'b000;
    localparam logic [OP_W-1:0] OP_ADD = 3'b001;
    localparam logic [OP_W-1:0] OP_SUB = 3'b010;
    localparam logic [OP_W-1:0] OP_AND = 3'b011;
    localparam logic [OP_W-1:0] OP_OR  = 3'b100;
    localparam logic [OP_W-1:0] OP_XOR = 3'b101;
    localparam logic [OP_W-1:0] OP_SHL = 3'b110;
    localparam logic [OP_W-1:0] OP_LI  = 3'b111;

    // The ALU works on the widest supported word; callers truncate to DATA_W,
    // which gives modulo-2^DATA_W arithmetic for every operation.
    localparam int MAX_W = 64;
    typedef logic [MAX_W-1:0] word_t;

    // Every opcode except NOP writes its destination register.
    function automatic logic is_write(input logic [OP_W-1:0] op);
        return op != OP_NOP;
    endfunction

    // sh_w is clog2(DATA_W): only that many low bits of b form the shift amount.
    function automatic word_t alu(input logic [OP_W-1:0] op, input word_t a,
                                  input word_t b, input word_t imm, input int sh_w);
        word_t mask;
        mask = (word_t'(1) << sh_w) - word_t'(1);
        case (op)
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            OP_XOR:  return a ^ b;
            OP_SHL:  return a << (b & mask);
            OP_LI:   return imm;
            default: return '0;
        endcase
    endfunction

endpackage

// File: rtl/simple_pipe_scoreboard.sv
// Per-register pipeline occupancy: bit1 = a writer of this register is in EX,
// bit0 = a writer is in WB. Drives operand-forwarding selection in ID.
module simple_pipe_scoreboard
    import simple_pipe_pkg::*;
#(
    parameter int NREG   = 4,
    parameter int REG_AW = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              shift_en,
    input  logic              set_en,
    input  logic [REG_AW-1:0] set_rd,
    input  logic [REG_AW-1:0] rs1,
    input  logic [REG_AW-1:0] rs2,
    output logic [1:0]        rs1_info,
    output logic [1:0]        rs2_info
);

    logic [1:0] sb [NREG];

    // Every progressing cycle each entry moves one stage along; a newly
    // accepted writer marks its destination as occupied in EX.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) sb[i] <= 2'b00;
        end else if (shift_en) begin
            for (int i = 0; i < NREG; i++)
                sb[i] <= {set_en && (set_rd == REG_AW'(i)), sb[i][1]};
        end
    end

    assign rs1_info = sb[rs1];
    assign rs2_info = sb[rs2];

endmodule

// File: rtl/simple_pipe_param.sv
// Three-stage ID/EX/WB pipeline with full forwarding, stall handshake,
// write-back observation port and a retired-write counter.
// Handshake: an instruction is taken on a rising edge where inst_valid and
// inst_ready are both high; inst_ready is simply !stall, so it never depends
// on inst_valid.
module simple_pipe_param
    import simple_pipe_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int NREG   = 4,
    parameter int CNT_W  = 16,
    localparam int REG_AW = $clog2(NREG),
    localparam int INST_W = OP_W + 3 * REG_AW
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [INST_W-1:0] inst,
    input  logic              inst_valid,
    output logic              inst_ready,
    input  logic              stall,
    input  logic [REG_AW-1:0] dbg_rd,
    output logic [DATA_W-1:0] dbg_rd_data,
    output logic              wb_valid,
    output logic [REG_AW-1:0] wb_rd,
    output logic [DATA_W-1:0] wb_data,
    output logic [CNT_W-1:0]  retire_cnt
);

    localparam int SH_W  = $clog2(DATA_W);
    localparam int IMM_W = 2 * REG_AW;

    // Instruction fields, MSB first: op, rs1, rs2, rd. LI's immediate is the
    // concatenated rs1/rs2 field.
    logic [OP_W-1:0]   id_op;
    logic [REG_AW-1:0] id_rs1, id_rs2, id_rd;
    logic [IMM_W-1:0]  id_imm;

    assign id_op  = inst[INST_W-1 -: OP_W];
    assign id_rs1 = inst[3*REG_AW-1 -: REG_AW];
    assign id_rs2 = inst[2*REG_AW-1 -: REG_AW];
    assign id_rd  = inst[REG_AW-1:0];
    assign id_imm = inst[IMM_W+REG_AW-1:REG_AW];

    logic accept;
    assign inst_ready = !stall;
    assign accept     = inst_valid && inst_ready;

    logic [DATA_W-1:0] regs [NREG];

    // ID/EX stage registers
    logic              ex_we;
    logic [OP_W-1:0]   ex_op;
    logic [REG_AW-1:0] ex_rd;
    logic [DATA_W-1:0] ex_a, ex_b;
    logic [IMM_W-1:0]  ex_imm;
    logic [DATA_W-1:0] ex_result;

    assign ex_result = DATA_W'(alu(ex_op, word_t'(ex_a), word_t'(ex_b),
                                   word_t'(ex_imm), SH_W));

    logic [1:0] rs1_info, rs2_info;

    simple_pipe_scoreboard #(
        .NREG   (NREG),
        .REG_AW (REG_AW)
    ) u_sb (
        .clk      (clk),
        .rst      (rst),
        .shift_en (!stall),
        .set_en   (accept && is_write(id_op)),
        .set_rd   (id_rd),
        .rs1      (id_rs1),
        .rs2      (id_rs2),
        .rs1_info (rs1_info),
        .rs2_info (rs2_info)
    );

    // Operand select: youngest producer (EX) first, then WB, then register file.
    logic [DATA_W-1:0] op_a, op_b;
    always_comb begin
        op_a = regs[id_rs1];
        op_b = regs[id_rs2];
        if (rs1_info[1])      op_a = ex_result;
        else if (rs1_info[0]) op_a = wb_data;
        if (rs2_info[1])      op_b = ex_result;
        else if (rs2_info[0]) op_b = wb_data;
    end

    // Pipeline advance; a cycle without accept injects a NOP bubble into EX.
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_we    <= 1'b0;
            ex_op    <= OP_NOP;
            ex_rd    <= '0;
            ex_a     <= '0;
            ex_b     <= '0;
            ex_imm   <= '0;
            wb_valid <= 1'b0;
            wb_rd    <= '0;
            wb_data  <= '0;
        end else if (!stall) begin
            ex_we    <= accept && is_write(id_op);
            ex_op    <= accept ? id_op : OP_NOP;
            ex_rd    <= id_rd;
            ex_a     <= op_a;
            ex_b     <= op_b;
            ex_imm   <= id_imm;
            wb_valid <= ex_we;
            wb_rd    <= ex_rd;
            wb_data  <= ex_result;
        end
    end

    // Register file write from WB, with the retired-write counter alongside.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
            retire_cnt <= '0;
        end else if (wb_valid && !stall) begin
            regs[wb_rd] <= wb_data;
            retire_cnt  <= retire_cnt + CNT_W'(1);
        end
    end

    assign dbg_rd_data = regs[dbg_rd];

endmodule

// File: tb/tb_simple_pipe_param.sv
// Self-checking bench for simple_pipe_param (DATA_W=8, NREG=4): directed
// sequences, an ALU vector table and randomized traffic against an
// in-order architectural model.
module tb_simple_pipe_param;

  localparam int DATA_W = 8;
  localparam int NREG   = 4;
  localparam int INST_W = 9;

  logic clk = 1'b0;
  logic rst, stall, inst_valid;
  logic [INST_W-1:0] inst;
  logic [1:0] dbg_rd;

  logic        inst_ready, wb_valid;
  logic [1:0]  wb_rd;
  logic [7:0]  dbg_rd_data, wb_data;
  logic [15:0] retire_cnt;

  logic        inst_ready4, wb_valid4;
  logic [1:0]  wb_rd4;
  logic [7:0]  dbg_rd_data4, wb_data4;
  logic [3:0]  retire_cnt4;

  simple_pipe_param #(.DATA_W(DATA_W), .NREG(NREG), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .inst(inst), .inst_valid(inst_valid),
    .inst_ready(inst_ready), .stall(stall), .dbg_rd(dbg_rd),
    .dbg_rd_data(dbg_rd_data), .wb_valid(wb_valid), .wb_rd(wb_rd),
    .wb_data(wb_data), .retire_cnt(retire_cnt)
  );

  simple_pipe_param #(.DATA_W(DATA_W), .NREG(NREG), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .inst(inst), .inst_valid(inst_valid),
    .inst_ready(inst_ready4), .stall(stall), .dbg_rd(dbg_rd),
    .dbg_rd_data(dbg_rd_data4), .wb_valid(wb_valid4), .wb_rd(wb_rd4),
    .wb_data(wb_data4), .retire_cnt(retire_cnt4)
  );

  // clock / reset
  always #5 clk = ~clk;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; stall = 1'b0; inst_valid = 1'b0; inst = '0; dbg_rd = '0;
    step();
    step();
    rst = 1'b0;
  endtask

  function automatic logic [INST_W-1:0] mk(input logic [2:0] op, input logic [1:0] a,
                                           input logic [1:0] b, input logic [1:0] d);
    return {op, a, b, d};
  endfunction

  function automatic logic [INST_W-1:0] mk_li(input logic [3:0] imm, input logic [1:0] d);
    return {3'b111, imm, d};
  endfunction

  task automatic issue(input logic [INST_W-1:0] w);
    inst = w; inst_valid = 1'b1; stall = 1'b0;
    step();
    inst_valid = 1'b0;
  endtask

  task automatic bubble(input int n);
    inst_valid = 1'b0; stall = 1'b0;
    repeat (n) step();
  endtask

  task automatic check_reg(input string name, input logic [1:0] r, input logic [7:0] exp);
    dbg_rd = r;
    #1;
    check(name, 32'(dbg_rd_data), 32'(exp));
  endtask

  // reference model: architectural state in program order plus committed state
  logic [7:0] arch_rf [NREG];
  logic [7:0] com_rf  [NREG];
  logic [9:0] exp_q [$];
  int com_cnt;

  function automatic logic [7:0] ref_alu(input logic [2:0] op, input logic [7:0] a,
                                         input logic [7:0] b, input logic [3:0] imm);
    int ia, ib;
    ia = int'(a); ib = int'(b);
    case (op)
      3'd1: return 8'((ia + ib) % 256);
      3'd2: return 8'((ia - ib + 256) % 256);
      3'd3: return a & b;
      3'd4: return a | b;
      3'd5: return a ^ b;
      3'd6: return 8'((ia * (1 << (ib % 8))) % 256);
      3'd7: return 8'(imm);
      default: return 8'h00;
    endcase
  endfunction

  // One randomized (or draining) cycle: outputs are judged against the model
  // before the edge, then the model absorbs what the edge will do.
  task automatic rnd_cycle(input bit drive);
    logic [2:0] op;
    logic [1:0] r1, r2, d;
    logic [7:0] v;
    logic [9:0] e;
    if (drive) begin
      inst       = INST_W'($urandom);
      inst_valid = ($urandom_range(0, 3) != 0);
      stall      = ($urandom_range(0, 4) == 0);
    end else begin
      inst_valid = 1'b0;
      stall      = 1'b0;
    end
    dbg_rd = 2'($urandom_range(0, 3));
    #1;
    check("rnd_ready", 32'(inst_ready), 32'(!stall));
    check("rnd_dbg", 32'(dbg_rd_data), 32'(com_rf[dbg_rd]));
    check("rnd_cnt", 32'(retire_cnt), 32'(com_cnt % 65536));
    check("rnd_cnt4", 32'(retire_cnt4), 32'(com_cnt % 16));
    if (wb_valid && !stall) begin
      check("rnd_wb_expected", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("rnd_wb", 32'({wb_rd, wb_data}), 32'(e));
        com_rf[e[9:8]] = e[7:0];
        com_cnt++;
      end
    end
    if (inst_valid && !stall) begin
      op = inst[8:6]; r1 = inst[5:4]; r2 = inst[3:2]; d = inst[1:0];
      if (op != 3'd0) begin
        v = ref_alu(op, arch_rf[r1], arch_rf[r2], inst[5:2]);
        arch_rf[d] = v;
        exp_q.push_back({d, v});
      end
    end
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    string      name;
    logic [2:0] op;
    logic [3:0] a;
    logic [3:0] b;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs [9];
  logic [7:0] wb_data_hold;
  logic [1:0] wb_rd_hold;
  logic       wb_valid_hold;

  initial begin
    vecs[0] = '{"alu_add",     3'd1, 4'h5, 4'h3, 8'h08};
    vecs[1] = '{"alu_sub_neg", 3'd2, 4'h3, 4'h5, 8'hFE};
    vecs[2] = '{"alu_and",     3'd3, 4'hC, 4'hA, 8'h08};
    vecs[3] = '{"alu_or",      3'd4, 4'hC, 4'h5, 8'h0D};
    vecs[4] = '{"alu_xor",     3'd5, 4'hF, 4'hA, 8'h05};
    vecs[5] = '{"alu_shl",     3'd6, 4'h3, 4'h2, 8'h0C};
    vecs[6] = '{"alu_shl_max", 3'd6, 4'hF, 4'hF, 8'h80};
    vecs[7] = '{"alu_shl_mask",3'd6, 4'h1, 4'h9, 8'h02};
    vecs[8] = '{"alu_li",      3'd7, 4'h0, 4'h0, 8'h06};

    // reset state
    do_reset();
    check("rst_wb_valid", 32'(wb_valid), 32'd0);
    check("rst_wb_rd", 32'(wb_rd), 32'd0);
    check("rst_wb_data", 32'(wb_data), 32'd0);
    check("rst_retire_cnt", 32'(retire_cnt), 32'd0);
    check("rst_retire_cnt4", 32'(retire_cnt4), 32'd0);
    check("rst_inst_ready", 32'(inst_ready), 32'd1);
    for (int i = 0; i < NREG; i++) check_reg("rst_reg", 2'(i), 8'h00);

    // back-to-back forwarding from EX and WB
    issue(mk_li(4'd5, 2'd1));
    issue(mk_li(4'd3, 2'd2));
    issue(mk(3'd1, 2'd1, 2'd2, 2'd3));
    issue(mk(3'd2, 2'd2, 2'd1, 2'd0));
    bubble(3);
    check_reg("b2b_r3", 2'd3, 8'h08);
    check_reg("b2b_r0", 2'd0, 8'hFE);
    check("b2b_cnt", 32'(retire_cnt), 32'd4);

    // latency and register-file read after two bubbles
    do_reset();
    issue(mk_li(4'd7, 2'd1));
    check("lat_ex_no_wb", 32'(wb_valid), 32'd0);
    step();
    check("lat_wb_valid", 32'(wb_valid), 32'd1);
    check("lat_wb_rd", 32'(wb_rd), 32'd1);
    check("lat_wb_data", 32'(wb_data), 32'd7);
    check_reg("lat_rf_not_yet", 2'd1, 8'h00);
    step();
    check_reg("lat_rf_written", 2'd1, 8'h07);
    issue(mk(3'd1, 2'd1, 2'd1, 2'd2));
    bubble(3);
    check_reg("rf_read_r2", 2'd2, 8'h0E);

    // stall between producer and consumer; an instruction offered while
    // stalled must not be taken
    do_reset();
    issue(mk_li(4'd1, 2'd1));
    stall = 1'b1;
    inst = mk_li(4'hF, 2'd0);
    inst_valid = 1'b1;
    #1;
    wb_valid_hold = wb_valid; wb_rd_hold = wb_rd; wb_data_hold = wb_data;
    for (int i = 0; i < 3; i++) begin
      check("stall_ready", 32'(inst_ready), 32'd0);
      step();
      check("stall_wb_valid", 32'(wb_valid), 32'(wb_valid_hold));
      check("stall_wb_rd", 32'(wb_rd), 32'(wb_rd_hold));
      check("stall_wb_data", 32'(wb_data), 32'(wb_data_hold));
    end
    inst_valid = 1'b0;
    issue(mk(3'd6, 2'd1, 2'd1, 2'd2));
    bubble(3);
    check_reg("stall_shl_r2", 2'd2, 8'h02);
    check_reg("stall_no_accept_r0", 2'd0, 8'h00);
    check("stall_cnt", 32'(retire_cnt), 32'd2);

    // same rd on consecutive cycles: youngest wins
    do_reset();
    issue(mk_li(4'd9, 2'd3));
    issue(mk_li(4'd4, 2'd3));
    issue(mk(3'd5, 2'd3, 2'd3, 2'd0));
    issue(mk(3'd4, 2'd3, 2'd3, 2'd1));
    bubble(3);
    check_reg("young_r0", 2'd0, 8'h00);
    check_reg("young_r1", 2'd1, 8'h04);
    check_reg("young_r3", 2'd3, 8'h04);

    // reset (together with stall) discards an in-flight write
    do_reset();
    issue(mk_li(4'hF, 2'd2));
    rst = 1'b1; stall = 1'b1;
    step();
    rst = 1'b0; stall = 1'b0;
    bubble(3);
    check_reg("rst_flush_r2", 2'd2, 8'h00);
    check("rst_flush_cnt", 32'(retire_cnt), 32'd0);

    // counter wrap with CNT_W=4
    do_reset();
    for (int i = 0; i < 17; i++) issue(mk_li(4'(i), 2'(i)));
    bubble(3);
    check("wrap_cnt16", 32'(retire_cnt), 32'd17);
    check("wrap_cnt4", 32'(retire_cnt4), 32'd1);

    // ALU vector table
    do_reset();
    for (int i = 0; i < 9; i++) begin
      issue(mk_li(vecs[i].a, 2'd1));
      issue(mk_li(vecs[i].b, 2'd2));
      issue(mk(vecs[i].op, 2'd1, 2'd2, 2'd3));
      bubble(3);
      check_reg(vecs[i].name, 2'd3, vecs[i].exp);
    end

    // randomized traffic against the architectural model
    do_reset();
    for (int i = 0; i < NREG; i++) begin
      arch_rf[i] = 8'h00;
      com_rf[i]  = 8'h00;
    end
    exp_q.delete();
    com_cnt = 0;
    for (int c = 0; c < 600; c++) rnd_cycle(1'b1);
    for (int c = 0; c < 4; c++) rnd_cycle(1'b0);
    check("rnd_drained", 32'(exp_q.size()), 32'd0);
    for (int i = 0; i < NREG; i++) check_reg("rnd_final_reg", 2'(i), arch_rf[i]);
    check("rnd_final_cnt", 32'(retire_cnt), 32'(com_cnt % 65536));

    // final report
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
